// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and address-decode helpers for the register file.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  // Byte-offset bits below the register index.
  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int idx_width(input int num_regs);
    return $clog2(num_regs);
  endfunction

endpackage

// File: rtl/axil_hold_reg.sv
// One-entry valid/data holding register; accepts while empty or while being drained.
module axil_hold_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [W-1:0] din,
  input  logic         drain,
  output logic         ready,
  output logic         held,
  output logic [W-1:0] dout
);

  assign ready = !held || drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      held <= 1'b0;
      dout <= '0;
    end else if (valid && ready) begin
      held <= 1'b1;
      dout <= din;
    end else if (drain) begin
      held <= 1'b0;
    end
  end

endmodule

// File: rtl/axil_regfile.sv
// AXI4-Lite register bank: independent AW/W holding, byte strobes, read-only mask,
// SLVERR/DECERR responses and per-register access pulses toward user logic.
module axil_regfile
  import axil_pkg::*;
#(
  parameter int                                      axil_addr_width = 32,
  parameter int                                      axil_data_width = 32,
  parameter int                                      num_regs        = 16,
  parameter logic [num_regs-1:0]                     ro_mask         = '0,
  parameter logic [num_regs*axil_data_width-1:0]     reset_values    = '0
) (
  input  logic                                   s_axi_aclk,
  input  logic                                   s_axi_areset,
  input  logic                                   s_axi_awvalid,
  output logic                                   s_axi_awready,
  input  logic [axil_addr_width-1:0]             s_axi_awaddr,
  input  logic [2:0]                             s_axi_awprot,
  input  logic                                   s_axi_wvalid,
  output logic                                   s_axi_wready,
  input  logic [axil_data_width-1:0]             s_axi_wdata,
  input  logic [axil_data_width/8-1:0]           s_axi_wstrb,
  output logic                                   s_axi_bvalid,
  input  logic                                   s_axi_bready,
  output logic [1:0]                             s_axi_bresp,
  input  logic                                   s_axi_arvalid,
  output logic                                   s_axi_arready,
  input  logic [axil_addr_width-1:0]             s_axi_araddr,
  input  logic [2:0]                             s_axi_arprot,
  output logic                                   s_axi_rvalid,
  input  logic                                   s_axi_rready,
  output logic [axil_data_width-1:0]             s_axi_rdata,
  output logic [1:0]                             s_axi_rresp,
  output logic [num_regs*axil_data_width-1:0]    reg_out,
  input  logic [num_regs*axil_data_width-1:0]    reg_in,
  output logic [num_regs-1:0]                    wr_pulse,
  output logic [num_regs-1:0]                    rd_pulse
);

  localparam int AW    = axil_addr_width;
  localparam int DW    = axil_data_width;
  localparam int SW    = DW / 8;
  localparam int LSB   = addr_lsb(DW);
  localparam int IDX_W = idx_width(num_regs);

  logic                              aw_held, w_held, commit;
  logic [AW-1:0]                     aw_addr_q;
  logic [DW-1:0]                     w_data_q;
  logic [SW-1:0]                     w_strb_q;
  logic [IDX_W-1:0]                  w_idx, r_idx;
  logic                              w_oor, r_oor, ar_fire;
  logic [num_regs-1:0][DW-1:0]       regs;
  logic [num_regs-1:0][DW-1:0]       reg_in_a;
  axi_resp_e                         b_resp_nxt, r_resp_nxt;
  logic                              unused_prot;

  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};
  assign reg_in_a    = reg_in;

  // A held pair retires whenever the B slot is free or being emptied this cycle.
  assign commit = aw_held && w_held && (!s_axi_bvalid || s_axi_bready);

  axil_hold_reg #(.W(AW)) u_aw_hold (
    .clk   (s_axi_aclk),
    .rst   (s_axi_areset),
    .valid (s_axi_awvalid),
    .din   (s_axi_awaddr),
    .drain (commit),
    .ready (s_axi_awready),
    .held  (aw_held),
    .dout  (aw_addr_q)
  );

  axil_hold_reg #(.W(DW + SW)) u_w_hold (
    .clk   (s_axi_aclk),
    .rst   (s_axi_areset),
    .valid (s_axi_wvalid),
    .din   ({s_axi_wstrb, s_axi_wdata}),
    .drain (commit),
    .ready (s_axi_wready),
    .held  (w_held),
    .dout  ({w_strb_q, w_data_q})
  );

  // Any address bit above the index field selects nothing in this bank.
  assign w_idx = aw_addr_q[LSB +: IDX_W];
  assign w_oor = |(aw_addr_q >> (LSB + IDX_W));
  assign r_idx = s_axi_araddr[LSB +: IDX_W];
  assign r_oor = |(s_axi_araddr >> (LSB + IDX_W));

  assign s_axi_arready = !s_axi_rvalid || s_axi_rready;
  assign ar_fire       = s_axi_arvalid && s_axi_arready;

  for (genvar i = 0; i < num_regs; i++) begin : g_reg
    if (ro_mask[i]) begin : g_ro
      assign regs[i] = reg_in_a[i];
    end else begin : g_rw
      logic [DW-1:0] q;
      always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
          q <= reset_values[i*DW +: DW];
        end else if (commit && !w_oor && w_idx == IDX_W'(i)) begin
          for (int k = 0; k < SW; k++)
            if (w_strb_q[k]) q[8*k +: 8] <= w_data_q[8*k +: 8];
        end
      end
      assign regs[i] = q;
    end
  end

  assign reg_out = regs;

  always_comb begin
    b_resp_nxt = OKAY;
    if (w_oor)                b_resp_nxt = DECERR;
    else if (ro_mask[w_idx])  b_resp_nxt = SLVERR;
    r_resp_nxt = r_oor ? DECERR : OKAY;
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= OKAY;
    end else if (commit) begin
      s_axi_bvalid <= 1'b1;
      s_axi_bresp  <= b_resp_nxt;
    end else if (s_axi_bready) begin
      s_axi_bvalid <= 1'b0;
    end
  end

  // Registers still hold pre-commit contents here, so a same-cycle read sees the old value.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= OKAY;
    end else if (ar_fire) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rresp  <= r_resp_nxt;
      s_axi_rdata  <= r_oor ? '0 : regs[r_idx];
    end else if (s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      wr_pulse <= '0;
      rd_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      rd_pulse <= '0;
      if (commit && !w_oor && !ro_mask[w_idx]) wr_pulse[w_idx] <= 1'b1;
      if (ar_fire && !r_oor)                   rd_pulse[r_idx] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axil_regfile.sv
// Directed and randomized checks of axil_regfile against a behavioural register-bank model.
`timescale 1ns/1ps
module tb_axil_regfile;

  localparam int AW = 32, DW = 32, N = 16;
  localparam logic [N-1:0] RO = 16'h0008;

  function automatic logic [N*DW-1:0] mk_rv();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++)
      v[i*DW +: DW] = (i == 2) ? 32'hAAAA_AAAA : 32'h1000_0000 + 32'(i * 273);
    return v;
  endfunction
  localparam logic [N*DW-1:0] RV = mk_rv();

  logic clk, rst;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [N*DW-1:0] reg_out, reg_in;
  logic [N-1:0] wr_pulse, rd_pulse;

  logic [DW-1:0] mem [N];
  logic [DW-1:0] rin [N];
  int checks, errors;

  axil_regfile #(
    .axil_addr_width(AW), .axil_data_width(DW), .num_regs(N),
    .ro_mask(RO), .reset_values(RV)
  ) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arprot(3'b000),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    reg_in = '0;
    for (int i = 0; i < N; i++) reg_in[i*DW +: DW] = rin[i];
  end

  // ---- reference model ----
  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) & 32'hF);
  endfunction
  function automatic bit oor_of(input logic [31:0] a);
    return (a >> 6) != 0;
  endfunction
  function automatic logic [1:0] exp_wresp(input logic [31:0] a);
    if (oor_of(a)) return 2'b11;
    if (RO[idx_of(a)]) return 2'b10;
    return 2'b00;
  endfunction
  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (oor_of(a)) return 32'h0;
    if (RO[idx_of(a)]) return rin[idx_of(a)];
    return mem[idx_of(a)];
  endfunction
  task automatic model_reset();
    for (int i = 0; i < N; i++) mem[i] = RV[i*DW +: DW];
  endtask
  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int i = idx_of(a);
    if (oor_of(a) || RO[i]) return;
    for (int k = 0; k < 4; k++) if (s[k]) mem[i][8*k +: 8] = d[8*k +: 8];
  endtask
  function automatic bit regs_match();
    for (int i = 0; i < N; i++)
      if (!RO[i] && reg_out[i*DW +: DW] !== mem[i]) return 0;
    return 1;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Full single write with bready=1; returns response and OR of wr_pulse seen.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [N-1:0] pulses);
    bit aw_done = 0, w_done = 0, got = 0;
    int cyc = 0;
    resp = 2'bxx; pulses = '0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    while (!got && cyc < 50) begin
      #1;
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      if (bvalid) begin got = 1; resp = bresp; end
      tick(); cyc++;
      if (aw_done) awvalid = 0;
      if (w_done) wvalid = 0;
      pulses |= wr_pulse;
    end
    awvalid = 0; wvalid = 0;
    if (!got) begin checks++; errors++; $display("FAIL write_timeout addr=%h", a); end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output logic [N-1:0] pulses);
    bit ar_done = 0, got = 0;
    int cyc = 0;
    d = 'x; resp = 2'bxx; pulses = '0;
    araddr = a; arvalid = 1; rready = 1;
    while (!got && cyc < 50) begin
      #1;
      if (arvalid && arready) ar_done = 1;
      if (rvalid) begin got = 1; d = rdata; resp = rresp; end
      tick(); cyc++;
      if (ar_done) arvalid = 0;
      pulses |= rd_pulse;
    end
    arvalid = 0;
    if (!got) begin checks++; errors++; $display("FAIL read_timeout addr=%h", a); end
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    model_reset();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      errors++; $display("FAIL reset_hs got=%b exp=11100", {awready, wready, arready, bvalid, rvalid});
    end
    checks++;
    if (rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00 || wr_pulse !== '0 || rd_pulse !== '0) begin
      errors++; $display("FAIL reset_out rdata=%h bresp=%b rresp=%b wp=%h rp=%h exp all zero",
                        rdata, bresp, rresp, wr_pulse, rd_pulse);
    end
    checks++;
    if (!regs_match()) begin errors++; $display("FAIL reset_regs got=%h exp=%h", reg_out, RV); end
  endtask

  task automatic test_write_same_cycle();
    awaddr = 32'h04; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    #1;
    checks++;
    if (!(awready && wready)) begin errors++; $display("FAIL ws_ready got=%b%b exp=11", awready, wready); end
    tick(); awvalid = 0; wvalid = 0;
    checks++;
    if (bvalid !== 1'b0 || wr_pulse !== '0) begin
      errors++; $display("FAIL ws_early bvalid=%b wp=%h exp 0/0", bvalid, wr_pulse);
    end
    tick();
    model_write(32'h04, 32'hDEAD_BEEF, 4'hF);
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || wr_pulse !== 16'h0002 || reg_out[1*DW +: DW] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ws_commit bvalid=%b bresp=%b wp=%h reg1=%h exp 1/00/0002/deadbeef",
                        bvalid, bresp, wr_pulse, reg_out[1*DW +: DW]);
    end
    tick();
    checks++;
    if (bvalid !== 1'b0 || wr_pulse !== '0) begin
      errors++; $display("FAIL ws_after bvalid=%b wp=%h exp 0/0", bvalid, wr_pulse);
    end
  endtask

  task automatic test_w_before_aw();
    int nb = 0;
    wdata = 32'h1234_5678; wstrb = 4'b0011; wvalid = 1; bready = 1;
    tick(); wvalid = 0;
    tick(); tick();
    awaddr = 32'h08; awvalid = 1;
    tick(); awvalid = 0;
    model_write(32'h08, 32'h1234_5678, 4'b0011);
    for (int c = 0; c < 6; c++) begin
      if (bvalid) begin
        nb++;
        checks++;
        if (bresp !== 2'b00) begin errors++; $display("FAIL wlead_resp got=%b exp=00", bresp); end
      end
      tick();
    end
    checks++;
    if (nb != 1) begin errors++; $display("FAIL wlead_bcount got=%0d exp=1", nb); end
    checks++;
    if (reg_out[2*DW +: DW] !== 32'hAAAA_5678) begin
      errors++; $display("FAIL wlead_reg2 got=%h exp=aaaa5678", reg_out[2*DW +: DW]);
    end
  endtask

  task automatic test_back_to_back_reads();
    logic [31:0] addrs [4];
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8; addrs[3] = 32'h0;
    rready = 1; arvalid = 1;
    for (int b = 0; b < 4; b++) begin
      if (b < 3) araddr = addrs[b]; else arvalid = 0;
      #1;
      if (b < 3) begin
        checks++;
        if (arready !== 1'b1) begin errors++; $display("FAIL b2b_arready beat=%0d got=0 exp=1", b); end
      end
      if (b > 0) begin
        checks++;
        if (rvalid !== 1'b1 || rdata !== exp_rdata(addrs[b-1]) || rresp !== 2'b00 ||
            rd_pulse !== (16'h1 << idx_of(addrs[b-1]))) begin
          errors++; $display("FAIL b2b_data beat=%0d rvalid=%b rdata=%h rp=%h exp 1/%h/%h",
                            b, rvalid, rdata, rd_pulse, exp_rdata(addrs[b-1]), 16'h1 << idx_of(addrs[b-1]));
        end
      end
      tick();
    end
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end rvalid=%b exp=0", rvalid); end
  endtask

  task automatic test_rready_stall();
    rready = 0; araddr = 32'h04; arvalid = 1;
    tick();
    araddr = 32'h08;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (rvalid !== 1'b1 || rdata !== exp_rdata(32'h04) || arready !== 1'b0) begin
        errors++; $display("FAIL stall c=%0d rvalid=%b rdata=%h arready=%b exp 1/%h/0",
                          c, rvalid, rdata, arready, exp_rdata(32'h04));
      end
      tick();
    end
    rready = 1;
    #1;
    checks++;
    if (arready !== 1'b1) begin errors++; $display("FAIL stall_release arready=%b exp=1", arready); end
    tick(); arvalid = 0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== exp_rdata(32'h08)) begin
      errors++; $display("FAIL stall_next rvalid=%b rdata=%h exp 1/%h", rvalid, rdata, exp_rdata(32'h08));
    end
    tick();
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL stall_end rvalid=%b exp=0", rvalid); end
  endtask

  task automatic test_readonly();
    logic [1:0] r; logic [N-1:0] p; logic [31:0] d;
    axi_write(32'h0C, 32'h1111_1111, 4'hF, r, p);
    checks++;
    if (r !== 2'b10 || p !== '0) begin errors++; $display("FAIL ro_write resp=%b wp=%h exp 10/0", r, p); end
    axi_read(32'h0C, d, r, p);
    checks++;
    if (d !== 32'hCAFE_0000 || r !== 2'b00 || p !== 16'h0008) begin
      errors++; $display("FAIL ro_read data=%h resp=%b rp=%h exp cafe0000/00/0008", d, r, p);
    end
  endtask

  task automatic test_decerr_and_reset();
    logic [1:0] r; logic [N-1:0] p; logic [31:0] d;
    int cyc = 0;
    axi_write(32'h1000, 32'h7777_7777, 4'hF, r, p);
    checks++;
    if (r !== 2'b11 || p !== '0 || !regs_match()) begin
      errors++; $display("FAIL dec_write resp=%b wp=%h regs_ok=%0d exp 11/0/1", r, p, regs_match());
    end
    axi_read(32'h1000, d, r, p);
    checks++;
    if (d !== 32'h0 || r !== 2'b11 || p !== '0) begin
      errors++; $display("FAIL dec_read data=%h resp=%b rp=%h exp 0/11/0", d, r, p);
    end
    // Leave a write response pending, then reset underneath it.
    bready = 0; awaddr = 32'h10; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick(); awvalid = 0; wvalid = 0;
    while (!bvalid && cyc < 10) begin tick(); cyc++; end
    checks++;
    if (bvalid !== 1'b1 || reg_out[4*DW +: DW] !== 32'h55) begin
      errors++; $display("FAIL rst_pre bvalid=%b reg4=%h exp 1/00000055", bvalid, reg_out[4*DW +: DW]);
    end
    rst = 1; tick(); rst = 0;
    model_reset();
    checks++;
    if (bvalid !== 1'b0 || !regs_match() || awready !== 1'b1 || wready !== 1'b1) begin
      errors++; $display("FAIL rst_mid bvalid=%b regs_ok=%0d awready=%b wready=%b exp 0/1/1/1",
                        bvalid, regs_match(), awready, wready);
    end
    bready = 1;
  endtask

  task automatic test_random_writes(input int nw);
    logic [31:0] qa[$]; logic [31:0] qd[$]; logic [3:0] qs[$];
    logic [31:0] fa[$]; logic [35:0] fw[$]; logic [1:0] bexp[$];
    int wexp[N]; int wobs[N];
    int cyc = 0;
    bit aw_f, w_f;
    logic [31:0] a; logic [35:0] x;
    for (int i = 0; i < N; i++) begin wexp[i] = 0; wobs[i] = 0; end
    for (int i = 0; i < nw; i++) begin
      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(6, 31));
      qa.push_back(a); qd.push_back($urandom); qs.push_back(4'($urandom_range(0, 15)));
    end
    awvalid = 0; wvalid = 0;
    while ((qa.size() != 0 || qd.size() != 0 || awvalid || wvalid || bexp.size() != 0 ||
            fa.size() != 0 || fw.size() != 0) && cyc < 3000) begin
      if (!awvalid && qa.size() != 0 && $urandom_range(0, 2) != 0) begin awaddr = qa.pop_front(); awvalid = 1; end
      if (!wvalid && qd.size() != 0 && $urandom_range(0, 2) != 0) begin
        wdata = qd.pop_front(); wstrb = qs.pop_front(); wvalid = 1;
      end
      bready = $urandom_range(0, 3) != 0;
      #1;
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      if (bvalid && bready) begin
        checks++;
        if (bexp.size() == 0) begin errors++; $display("FAIL rw_bresp got=%b exp=none", bresp); end
        else begin
          if (bresp !== bexp[0]) begin errors++; $display("FAIL rw_bresp got=%b exp=%b", bresp, bexp[0]); end
          void'(bexp.pop_front());
        end
      end
      if (aw_f) fa.push_back(awaddr);
      if (w_f) fw.push_back({wstrb, wdata});
      while (fa.size() != 0 && fw.size() != 0) begin
        a = fa.pop_front(); x = fw.pop_front();
        bexp.push_back(exp_wresp(a));
        model_write(a, x[31:0], x[35:32]);
        if (exp_wresp(a) == 2'b00) wexp[idx_of(a)]++;
      end
      tick(); cyc++;
      if (aw_f) awvalid = 0;
      if (w_f) wvalid = 0;
      for (int i = 0; i < N; i++) wobs[i] += int'(wr_pulse[i]);
    end
    awvalid = 0; wvalid = 0; bready = 1;
    checks++;
    if (cyc >= 3000) begin errors++; $display("FAIL rw_timeout cycles=%0d exp<3000", cyc); end
    for (int i = 0; i < N; i++) begin
      if (RO[i]) continue;
      checks++;
      if (reg_out[i*DW +: DW] !== mem[i] || wobs[i] != wexp[i]) begin
        errors++; $display("FAIL rw_reg%0d got=%h pulses=%0d exp=%h pulses=%0d",
                          i, reg_out[i*DW +: DW], wobs[i], mem[i], wexp[i]);
      end
    end
  endtask

  task automatic test_random_reads(input int nr);
    logic [31:0] qa[$]; logic [31:0] dexp[$]; logic [1:0] rexp[$];
    int pexp[N]; int pobs[N];
    int cyc = 0;
    bit ar_f;
    logic [31:0] a;
    for (int i = 0; i < N; i++) begin pexp[i] = 0; pobs[i] = 0; end
    for (int i = 0; i < nr; i++) begin
      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(6, 31));
      qa.push_back(a);
    end
    arvalid = 0;
    while ((qa.size() != 0 || arvalid || dexp.size() != 0) && cyc < 3000) begin
      if (!arvalid && qa.size() != 0 && $urandom_range(0, 3) != 0) begin araddr = qa.pop_front(); arvalid = 1; end
      rready = $urandom_range(0, 2) != 0;
      #1;
      ar_f = arvalid && arready;
      if (rvalid && rready) begin
        checks++;
        if (dexp.size() == 0) begin errors++; $display("FAIL rr_data got=%h exp=none", rdata); end
        else begin
          if (rdata !== dexp[0] || rresp !== rexp[0]) begin
            errors++; $display("FAIL rr_data got=%h/%b exp=%h/%b", rdata, rresp, dexp[0], rexp[0]);
          end
          void'(dexp.pop_front()); void'(rexp.pop_front());
        end
      end
      if (ar_f) begin
        dexp.push_back(exp_rdata(araddr));
        rexp.push_back(oor_of(araddr) ? 2'b11 : 2'b00);
        if (!oor_of(araddr)) pexp[idx_of(araddr)]++;
      end
      tick(); cyc++;
      if (ar_f) arvalid = 0;
      for (int i = 0; i < N; i++) pobs[i] += int'(rd_pulse[i]);
    end
    arvalid = 0; rready = 1;
    checks++;
    if (cyc >= 3000) begin errors++; $display("FAIL rr_timeout cycles=%0d exp<3000", cyc); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (pobs[i] != pexp[i]) begin
        errors++; $display("FAIL rr_pulse%0d got=%0d exp=%0d", i, pobs[i], pexp[i]);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    for (int i = 0; i < N; i++) rin[i] = $urandom;
    rin[3] = 32'hCAFE_0000;
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_back_to_back_reads();
    test_rready_stall();
    test_readonly();
    test_decerr_and_reset();
    test_random_writes(60);
    test_random_reads(60);
    test_random_writes(40);
    test_random_reads(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
